// File: rtl/peek_poke_bundle_pkg.sv
// Shared types and constants for the peek/poke bundle FIFO.
// The bundle packs MSB->LSB as {aUInt, aSInt, aBundle_aBool, aBottomBool}.
package peek_poke_bundle_pkg;

    localparam int UINT_W_DEF = 4;
    localparam int SINT_W_DEF = 5;
    localparam int XFER_CNT_W = 16;

    // Bundle layout at the default field widths.
    typedef struct packed {
        logic [UINT_W_DEF-1:0] aUInt;
        logic [SINT_W_DEF-1:0] aSInt;
        logic                  aBundle_aBool;
        logic                  aBottomBool;
    } bundle_t;

    // Flat width of a bundle for arbitrary field widths (two trailing bools).
    function automatic int bundle_width(input int uint_w, input int sint_w);
        return uint_w + sint_w + 2;
    endfunction

endpackage

// File: rtl/peek_poke_bundle_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are never cleared.
module peek_poke_bundle_ram #(
    parameter  int WIDTH  = 11,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    // One-hot write decode, one select bit per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // Store the incoming word into the selected entry.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/peek_poke_bundle_fifo.sv
// Elastic DEPTH-entry buffer for the peek/poke test-harness bundle.
// Output data is registered: the head register is loaded with the entry
// that will be at the head next cycle, so a push into an empty FIFO
// appears one cycle later and data is held stable under backpressure.
// Optional feature macro: PEEK_POKE_BUNDLE_FIFO_STATS_EN adds io_xfer_count.
module peek_poke_bundle_fifo
    import peek_poke_bundle_pkg::*;
#(
    parameter  int UINT_W = UINT_W_DEF,
    parameter  int SINT_W = SINT_W_DEF,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [UINT_W-1:0] io_in_aUInt,
    input  logic [SINT_W-1:0] io_in_aSInt,
    input  logic              io_in_aBundle_aBool,
    input  logic              io_in_aBottomBool,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [UINT_W-1:0] io_out_aUInt,
    output logic [SINT_W-1:0] io_out_aSInt,
    output logic              io_out_aBundle_aBool,
    output logic              io_out_aBottomBool,
    output logic [CNT_W-1:0]  io_count
`ifdef PEEK_POKE_BUNDLE_FIFO_STATS_EN
    ,
    output logic [XFER_CNT_W-1:0] io_xfer_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BW    = bundle_width(UINT_W, SINT_W);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [BW-1:0]    head_reg, head_next;
    logic [BW-1:0]    in_bundle;
    logic [BW-1:0]    ram_rd_data;
    logic             push;
    logic             pop;

    // Handshake is derived from occupancy only; a full FIFO refuses a push
    // even when the consumer pops in the same cycle.
    assign io_in_ready  = (count_reg != CNT_W'(DEPTH));
    assign io_out_valid = (count_reg != '0);
    assign push         = io_in_valid & io_in_ready;
    assign pop          = io_out_valid & io_out_ready;

    assign in_bundle = {io_in_aUInt, io_in_aSInt, io_in_aBundle_aBool, io_in_aBottomBool};

    peek_poke_bundle_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_bundle),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_rd_data)
    );

    // Next-state for pointers, occupancy and the head register.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        head_next   = head_reg;
        if (push && (rd_ptr_next == wr_ptr_reg)) begin
            // The entry being written now becomes the head: bypass the array.
            head_next = in_bundle;
        end else if (count_next != '0) begin
            head_next = ram_rd_data;
        end
    end

    // Pointer, occupancy and head registers; reset discards in-flight data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign io_out_aUInt         = head_reg[BW-1 -: UINT_W];
    assign io_out_aSInt         = head_reg[SINT_W+1 : 2];
    assign io_out_aBundle_aBool = head_reg[1];
    assign io_out_aBottomBool   = head_reg[0];
    assign io_count             = count_reg;

`ifdef PEEK_POKE_BUNDLE_FIFO_STATS_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_reg;

    // Accepted-push counter, wraps naturally at its width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xfer_cnt_reg <= '0;
        end else if (push) begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
        end
    end

    assign io_xfer_count = xfer_cnt_reg;
`endif

endmodule
